conf_pkt_gen: RTL and testbench
===============================

CONF_PKT_GEN -- requirements
Module: conf_pkt_gen

Interface
REQ-001 Parameter ETH_TYPE, default 16'h9005: ethertype for config request and response packets.
REQ-002 Parameter DST_MAC, default 48'h00_0A_35_00_00_01: head-flit destination MAC.
REQ-003 Parameter SRC_MAC, default 48'h00_0A_35_00_00_02: head-flit source MAC.
REQ-004 Parameter TIMEOUT, default 1024: wait limit for a read response, in cycles.
REQ-005 clk  input  1  clock.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-009 cmd_op  input  3  1=wr ITCM, 2=wr DTCM, 3=rd ITCM, 4=rd DTCM, 5=set sel_dtcm; others illegal.
REQ-010 cmd_addr  input  32  target word address.
REQ-011 cmd_wdata  input  32  write data; for op 5 only bit 0 is used.
REQ-012 pktout_data_wr  output  1  flit strobe.
REQ-013 pktout_data  output  134  flit: [133:132] tag (01 head, 10 tail), [131:128] invalid-byte count, [127:0] payload.
REQ-014 pktout_data_valid  output  1  packet-valid flag.
REQ-015 pktout_data_valid_wr  output  1  strobe for pktout_data_valid.
REQ-016 pktout_ready  input  1  downstream can absorb at least 2 flits.
REQ-017 pktin_data_wr  input  1  response flit strobe.
REQ-018 pktin_data  input  134  response flit, same format as pktout_data.
REQ-019 rsp_valid  output  1  response held until rsp_ready.
REQ-020 rsp_ready  input  1  response consumed.
REQ-021 rsp_err  output  1  1 = illegal op or timeout.
REQ-022 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-023 busy  output  1  high in every state except IDLE.

Function
REQ-024 The block SHALL implement five states: IDLE, HEAD, TAIL, WAIT_RSP and RSP.
REQ-025 cmd_ready SHALL be 1 only in IDLE.
REQ-026 On acceptance the block SHALL latch op, addr and wdata, assign seq = current counter, and increment the 8-bit counter with wrap (255 -> 0).
REQ-027 An illegal op SHALL go IDLE -> RSP with rsp_err=1, emit no flits, and still consume a sequence number.
REQ-028 HEAD SHALL emit the head flit only in a cycle with pktout_ready=1, else wait.
REQ-029 The head flit SHALL be: tag 01, [131:128]=0, [127:80]=DST_MAC, [79:32]=SRC_MAC, [31:16]=ETH_TYPE, [15:8]={5'b0,op}, [7:0]=seq.
REQ-030 TAIL SHALL emit the tail flit in the cycle after the head flit, unconditionally.
REQ-031 The tail flit SHALL be: tag 10, [131:128]=8, [127:96]=addr, [95:64]=wdata, [63:0]=0.
REQ-032 pktout_data_valid_wr SHALL pulse and pktout_data_valid SHALL be 1 in the tail cycle; pktout_data_valid_wr SHALL be 0 otherwise.
REQ-033 After the tail, ops 1, 2 and 5 SHALL go to RSP with rsp_err=0 and rsp_rdata=0, and ops 3 and 4 SHALL go to WAIT_RSP.
REQ-034 WAIT_RSP SHALL match a response as a head flit (tag 01) with [31:16]=ETH_TYPE, [15:8]={5'b10000,op} and [7:0]=seq, followed by the next tail flit (tag 10), and rsp_rdata SHALL take that tail's [127:96].
REQ-035 A match SHALL go to RSP with rsp_err=0 in the cycle after the tail is received.
REQ-036 In WAIT_RSP, non-matching packets SHALL be discarded through their tail flit, and a head arriving mid-discard SHALL restart parsing.
REQ-037 pktin flits arriving in any state other than WAIT_RSP SHALL be ignored.
REQ-038 The timeout counter SHALL clear on entering WAIT_RSP and increment each cycle.
REQ-039 When the timeout counter reaches TIMEOUT-1 with no match, the block SHALL go to RSP with rsp_err=1 and rsp_rdata=0.
REQ-040 A matching tail received in the same cycle as the timeout SHALL win (rsp_err=0).
REQ-041 In RSP, rsp_valid SHALL be 1 and rsp_err/rsp_rdata SHALL be stable, until rsp_valid & rsp_ready, then the block SHALL go to IDLE.
REQ-042 Between packets, pktout_data_wr SHALL be 0 and pktout_data SHALL hold its last value.

Reset
REQ-043 On rst_n=0 the block SHALL immediately go to IDLE.
REQ-044 On rst_n=0 the sequence counter and timeout counter SHALL clear to 0.
REQ-045 On rst_n=0 all outputs SHALL go to 0, except cmd_ready, which SHALL be 1 after release.
REQ-046 Reset between head and tail truncates the packet; no recovery flit is sent.

Verification
REQ-047 op=1, addr=0x10, wdata=0xDEADBEEF, pktout_ready=1 -> head flit with [15:0]=0x0100 on cycle+1, tail with [127:64]=0x00000010_DEADBEEF and valid_wr pulse on cycle+2, then rsp_valid=1, err=0.
REQ-048 op=3, addr=0x4, then response head op 0x83 seq 1 followed by a tail with [127:96]=0x12345678 -> rsp_rdata=0x12345678, err=0.
REQ-049 Read with a foreign-ethertype packet then a wrong-seq packet injected -> both ignored; no response within TIMEOUT=16 -> rsp_err=1 exactly 16 cycles after entering WAIT_RSP.
REQ-050 pktout_ready=0 for 5 cycles at HEAD -> no flit emitted; head and tail appear back-to-back after ready=1.
REQ-051 Drive 256 commands -> seq field wraps 0xFF -> 0x00; op=7 -> immediate rsp_err=1, no flits.
REQ-052 Assert rst_n low in WAIT_RSP with rsp_ready=0 -> busy=0, rsp_valid=0, next command uses seq 0.

Source files
------------

// File: rtl/conf_pkt_gen.sv
// Configuration packet generator: turns one command into a head+tail request
// packet, then waits for and parses the matching read response when needed.
module conf_pkt_gen #(
    parameter logic [15:0] ETH_TYPE = 16'h9005,
    parameter logic [47:0] DST_MAC  = 48'h00_0A_35_00_00_01,
    parameter logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_02,
    parameter int          TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [31:0]  cmd_addr,
    input  logic [31:0]  cmd_wdata,
    output logic         pktout_data_wr,
    output logic [133:0] pktout_data,
    output logic         pktout_data_valid,
    output logic         pktout_data_valid_wr,
    input  logic         pktout_ready,
    input  logic         pktin_data_wr,
    input  logic [133:0] pktin_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_err,
    output logic [31:0]  rsp_rdata,
    output logic         busy
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEAD     = 3'd1,
        TAIL     = 3'd2,
        WAIT_RSP = 3'd3,
        RSP      = 3'd4
    } state_t;

    state_t         state_reg;
    logic [2:0]     op_reg;
    logic [31:0]    addr_reg;
    logic [31:0]    wdata_reg;
    logic [7:0]     seq_reg;
    logic [7:0]     seq_cnt_reg;
    logic [TW-1:0]  to_cnt_reg;
    logic           hdr_ok_reg;

    logic           cmd_legal;
    logic           op_is_read;
    logic [1:0]     in_tag;
    logic           rsp_head_match;
    logic           rsp_tail_hit;
    logic           timeout_hit;
    logic [133:0]   head_flit;
    logic [133:0]   tail_flit;
    logic           unused_bits;

    assign cmd_legal  = (cmd_op >= 3'd1) && (cmd_op <= 3'd5);
    assign op_is_read = (op_reg == 3'd3) || (op_reg == 3'd4);

    assign head_flit = {TAG_HEAD, 4'd0, DST_MAC, SRC_MAC, ETH_TYPE, 5'd0, op_reg, seq_reg};
    assign tail_flit = {TAG_TAIL, 4'd8, addr_reg, wdata_reg, 64'd0};

    // A response is identified by ethertype, the op with its response bit set, and our seq.
    assign in_tag         = pktin_data[133:132];
    assign rsp_head_match = (in_tag == TAG_HEAD)
                         && (pktin_data[31:16] == ETH_TYPE)
                         && (pktin_data[15:8]  == {5'b10000, op_reg})
                         && (pktin_data[7:0]   == seq_reg);
    assign rsp_tail_hit   = pktin_data_wr && (in_tag == TAG_TAIL) && hdr_ok_reg;
    assign timeout_hit    = (to_cnt_reg == TO_LAST);

    assign unused_bits = ^{pktin_data[131:128], pktin_data[95:32]};

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= IDLE;
            op_reg               <= 3'd0;
            addr_reg             <= 32'd0;
            wdata_reg            <= 32'd0;
            seq_reg              <= 8'd0;
            seq_cnt_reg          <= 8'd0;
            to_cnt_reg           <= '0;
            hdr_ok_reg           <= 1'b0;
            pktout_data_wr       <= 1'b0;
            pktout_data          <= 134'd0;
            pktout_data_valid    <= 1'b0;
            pktout_data_valid_wr <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_err              <= 1'b0;
            rsp_rdata            <= 32'd0;
        end else begin
            pktout_data_wr       <= 1'b0;
            pktout_data_valid    <= 1'b0;
            pktout_data_valid_wr <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg      <= cmd_op;
                        addr_reg    <= cmd_addr;
                        wdata_reg   <= cmd_wdata;
                        seq_reg     <= seq_cnt_reg;
                        seq_cnt_reg <= seq_cnt_reg + 8'd1;
                        if (cmd_legal) begin
                            state_reg <= HEAD;
                        end else begin
                            // Illegal ops still burn a sequence number but send nothing.
                            state_reg <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
                    end
                end

                HEAD: begin
                    if (pktout_ready) begin
                        pktout_data_wr <= 1'b1;
                        pktout_data    <= head_flit;
                        state_reg      <= TAIL;
                    end
                end

                TAIL: begin
                    // pktout_ready promised room for two flits, so the tail never waits.
                    pktout_data_wr       <= 1'b1;
                    pktout_data          <= tail_flit;
                    pktout_data_valid    <= 1'b1;
                    pktout_data_valid_wr <= 1'b1;
                    if (op_is_read) begin
                        state_reg  <= WAIT_RSP;
                        to_cnt_reg <= '0;
                        hdr_ok_reg <= 1'b0;
                    end else begin
                        state_reg <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end
                end

                WAIT_RSP: begin
                    to_cnt_reg <= to_cnt_reg + TW'(1);
                    if (pktin_data_wr) begin
                        // Any head restarts parsing; any tail ends the current packet.
                        if (in_tag == TAG_HEAD) begin
                            hdr_ok_reg <= rsp_head_match;
                        end else if (in_tag == TAG_TAIL) begin
                            hdr_ok_reg <= 1'b0;
                        end
                    end
                    // A matching tail on the timeout cycle takes priority.
                    if (rsp_tail_hit) begin
                        state_reg <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= pktin_data[127:96];
                    end else if (timeout_hit) begin
                        state_reg <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conf_pkt_gen.sv
// Randomized bench for conf_pkt_gen: a transaction-level model predicts the
// request flits and the response outcome from the inbound flit schedule.
module tb_conf_pkt_gen;

    localparam int          TO  = 16;
    localparam logic [15:0] ETH = 16'h9005;
    localparam logic [47:0] DST = 48'h00_0A_35_00_00_01;
    localparam logic [47:0] SRC = 48'h00_0A_35_00_00_02;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [31:0]  cmd_addr = 32'd0;
    logic [31:0]  cmd_wdata = 32'd0;
    logic         pktout_data_wr;
    logic [133:0] pktout_data;
    logic         pktout_data_valid;
    logic         pktout_data_valid_wr;
    logic         pktout_ready = 1'b0;
    logic         pktin_data_wr = 1'b0;
    logic [133:0] pktin_data = 134'd0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_err;
    logic [31:0]  rsp_rdata;
    logic         busy;

    conf_pkt_gen #(.TIMEOUT(TO)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_addr             (cmd_addr),
        .cmd_wdata            (cmd_wdata),
        .pktout_data_wr       (pktout_data_wr),
        .pktout_data          (pktout_data),
        .pktout_data_valid    (pktout_data_valid),
        .pktout_data_valid_wr (pktout_data_valid_wr),
        .pktout_ready         (pktout_ready),
        .pktin_data_wr        (pktin_data_wr),
        .pktin_data           (pktin_data),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_err              (rsp_err),
        .rsp_rdata            (rsp_rdata),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [133:0] d;
    } flit_t;

    flit_t        flits[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           txn_id = 0;
    logic [7:0]   model_seq = 8'd0;
    logic [133:0] last_out = 134'd0;

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [95:0] junk96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [133:0] req_head(input logic [2:0] op, input logic [7:0] seq);
        return {2'b01, 4'h0, DST, SRC, ETH, 5'b00000, op, seq};
    endfunction

    function automatic logic [133:0] req_tail(input logic [31:0] addr, input logic [31:0] wdata);
        return {2'b10, 4'h8, addr, wdata, 64'h0};
    endfunction

    function automatic logic [133:0] in_head(input logic [15:0] eth, input logic [7:0] opb,
                                             input logic [7:0] seq);
        return {2'b01, 4'h0, junk96(), eth, opb, seq};
    endfunction

    function automatic logic [133:0] in_tail(input logic [31:0] data);
        return {2'b10, 4'h8, data, junk96()};
    endfunction

    task automatic push(input bit wr, input logic [133:0] d);
        flit_t f;
        f.wr = wr;
        f.d  = d;
        flits.push_back(f);
    endtask

    task automatic push_noise(input logic [2:0] op, input logic [7:0] seq);
        case ($urandom_range(0, 4))
            0: begin
                push(1, in_head(ETH ^ 16'($urandom_range(1, 65535)), {5'b10000, op}, seq));
                push(1, in_tail($urandom()));
            end
            1: begin
                push(1, in_head(ETH, {5'b10000, op}, seq + 8'($urandom_range(1, 255))));
                push(1, in_tail($urandom()));
            end
            2: begin
                push(1, in_head(ETH, {5'b10000, op ^ 3'($urandom_range(1, 7))}, seq));
                push(1, in_tail($urandom()));
            end
            3: push(1, in_tail($urandom()));
            default: begin
                push(1, in_head(ETH, {5'b00000, op}, seq));
                push(1, in_tail($urandom()));
            end
        endcase
    endtask

    // Inbound schedule: entry k-1 is presented for the k-th edge after entering the wait.
    task automatic build_flits(input logic [2:0] op, input logic [7:0] seq, input int mode,
                               input logic [31:0] rdata);
        logic [7:0] opb;
        opb = {5'b10000, op};
        flits.delete();
        case (mode)
            0: begin
                repeat ($urandom_range(0, 2)) push_noise(op, seq);
                if ($urandom_range(0, 1) == 1) push(0, 134'd0);
                if ($urandom_range(0, 2) == 0) push(1, in_head(ETH ^ 16'h0100, opb, seq));
                push(1, in_head(ETH, opb, seq));
                if ($urandom_range(0, 1) == 1) push(1, {2'b00, 4'h0, junk96(), $urandom()});
                if ($urandom_range(0, 1) == 1) push(0, 134'd0);
                push(1, in_tail(rdata));
            end
            1: begin
                repeat ($urandom_range(1, 3)) push_noise(op, seq);
                if ($urandom_range(0, 1) == 1) push(1, in_head(ETH, opb, seq));
            end
            2: begin
                for (int i = 0; i < TO - 2; i++) begin
                    if ($urandom_range(0, 3) == 0) push(1, in_tail($urandom()));
                    else push(0, 134'd0);
                end
                push(1, in_head(ETH, opb, seq));
                push(1, in_tail(rdata));
            end
            3: begin
                for (int i = 0; i < TO - 1; i++) push(0, 134'd0);
                push(1, in_head(ETH, opb, seq));
                push(1, in_tail(rdata));
            end
            4: begin
                push(1, in_head(16'h0800, opb, seq));
                push(1, in_tail(rdata));
                push(1, in_head(ETH, opb, seq + 8'd1));
                push(1, in_tail(rdata));
            end
            default: begin
                push(1, in_head(ETH, opb, seq));
                push(1, in_tail(rdata));
            end
        endcase
    endtask

    // First tail following an accepted head wins if it arrives by edge TO; else timeout at TO.
    task automatic model_rsp(input logic [2:0] op, input logic [7:0] seq,
                             output int kdone, output bit err, output logic [31:0] rd);
        bit           armed;
        logic [133:0] d;
        armed = 0;
        kdone = TO;
        err   = 1;
        rd    = 32'd0;
        for (int k = 1; k <= TO; k++) begin
            if (k - 1 < flits.size() && flits[k-1].wr) begin
                d = flits[k-1].d;
                if (d[133:132] == 2'b01) begin
                    armed = (d[31:16] == ETH) && (d[15:8] == {5'b10000, op}) && (d[7:0] == seq);
                end else if (d[133:132] == 2'b10) begin
                    if (armed) begin
                        kdone = k;
                        err   = 0;
                        rd    = d[127:96];
                        return;
                    end
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_out_wr", pktout_data_wr, 0);
        check("rst_out_data", pktout_data, 0);
        check("rst_vwr", pktout_data_valid_wr, 0);
        check("rst_valid", pktout_data_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        model_seq = 8'd0;
        last_out  = 134'd0;
    endtask

    // rst_at: 0 none, 1 reset between head and tail, 2 reset while waiting for a response.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, input int mode, input logic [31:0] rdata, input int rst_at);
        logic [7:0]  seq;
        int          kdone;
        bit          e_err;
        logic [31:0] e_rd;
        bit          legal;
        bit          rd;
        seq       = model_seq;
        model_seq = model_seq + 8'd1;
        legal = (op >= 3'd1) && (op <= 3'd5);
        rd    = (op == 3'd3) || (op == 3'd4);
        kdone = 0;
        e_err = !legal;
        e_rd  = 32'd0;
        if (rd) begin
            build_flits(op, seq, mode, rdata);
            model_rsp(op, seq, kdone, e_err, e_rd);
        end

        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_addr      = addr;
        cmd_wdata     = wdata;
        pktout_ready  = (stall == 0);
        pktin_data_wr = 1'($urandom_range(0, 1));
        pktin_data    = in_head(ETH, {5'b10000, op}, seq);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom());
        check("busy_after_accept", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);

        if (legal) begin
            for (int i = 0; i < stall; i++) begin
                pktin_data_wr = 1'($urandom_range(0, 1));
                pktin_data    = in_tail($urandom());
                @(posedge clk);
                #1;
                check("no_flit_stall", pktout_data_wr, 0);
                check("hold_data_stall", pktout_data, last_out);
            end
            pktout_ready  = 1'b1;
            pktin_data_wr = 1'b0;
            @(posedge clk);
            #1;
            check("head_wr", pktout_data_wr, 1);
            check("head_flit", pktout_data, req_head(op, seq));
            check("head_vwr", pktout_data_valid_wr, 0);
            last_out = req_head(op, seq);
            if (rst_at == 1) begin
                pulse_reset();
                @(posedge clk);
                #1;
                check("no_tail_after_rst", pktout_data_wr, 0);
                $display("txn %0d: op=%0d seq=%02h reset between head and tail", txn_id, op, seq);
                txn_id++;
                return;
            end
            pktout_ready  = 1'($urandom_range(0, 1));
            pktin_data_wr = 1'($urandom_range(0, 1));
            pktin_data    = in_head(ETH, {5'b10000, op}, seq);
            @(posedge clk);
            #1;
            pktout_ready  = 1'b0;
            pktin_data_wr = 1'b0;
            check("tail_wr", pktout_data_wr, 1);
            check("tail_flit", pktout_data, req_tail(addr, wdata));
            check("tail_vwr", pktout_data_valid_wr, 1);
            check("tail_valid", pktout_data_valid, 1);
            last_out = req_tail(addr, wdata);
            if (rd) begin
                if (rst_at == 2) begin
                    @(posedge clk);
                    #1;
                    check("wait_busy", busy, 1);
                    pulse_reset();
                    $display("txn %0d: op=%0d seq=%02h reset while waiting", txn_id, op, seq);
                    txn_id++;
                    return;
                end
                for (int k = 1; k <= kdone; k++) begin
                    if (k - 1 < flits.size()) begin
                        pktin_data_wr = flits[k-1].wr;
                        pktin_data    = flits[k-1].d;
                    end else begin
                        pktin_data_wr = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                    if (k == 1) check("vwr_after_tail", pktout_data_valid_wr, 0);
                    if (k < kdone) check("rsp_early", rsp_valid, 0);
                end
                pktin_data_wr = 1'b0;
            end
        end else begin
            pktin_data_wr = 1'b0;
        end

        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, e_err);
        check("rsp_rdata", rsp_rdata, e_rd);
        repeat ($urandom_range(0, 3)) begin
            pktin_data_wr = 1'($urandom_range(0, 1));
            pktin_data    = in_tail($urandom());
            @(posedge clk);
            #1;
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_err", rsp_err, e_err);
            check("rsp_hold_rdata", rsp_rdata, e_rd);
            check("rsp_no_flit", pktout_data_wr, 0);
            check("rsp_hold_data", pktout_data, last_out);
        end
        pktin_data_wr = 1'b0;
        rsp_ready     = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", cmd_ready, 1);
        $display("txn %0d: op=%0d seq=%02h addr=%h stall=%0d -> err=%0b rdata=%h",
                 txn_id, op, seq, addr, stall, e_err, e_rd);
        txn_id++;
    endtask

    initial begin
        logic [2:0] op;
        int         r;
        int         m;
        int         mode;
        #2;
        check("init_busy", busy, 0);
        check("init_rsp_valid", rsp_valid, 0);
        check("init_out_wr", pktout_data_wr, 0);
        check("init_out_data", pktout_data, 0);
        check("init_vwr", pktout_data_valid_wr, 0);
        #20;
        rst_n = 1'b1;
        #1;
        check("init_cmd_ready", cmd_ready, 1);

        do_cmd(3'd1, 32'h10, 32'hDEADBEEF, 0, 0, 32'd0, 0);
        do_cmd(3'd3, 32'h4, 32'h0, 0, 5, 32'h12345678, 0);
        do_cmd(3'd4, 32'h8, 32'h0, 0, 4, 32'hCAFEF00D, 0);
        do_cmd(3'd2, 32'h20, 32'h01234567, 5, 0, 32'd0, 0);
        do_cmd(3'd7, 32'h30, 32'h0, 0, 0, 32'd0, 0);
        do_cmd(3'd5, 32'h0, 32'h1, 1, 0, 32'd0, 0);
        do_cmd(3'd3, 32'h40, 32'h0, 2, 2, 32'hA5A5A5A5, 0);
        do_cmd(3'd4, 32'h44, 32'h0, 0, 3, 32'h5A5A5A5A, 0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r < 2) begin
                case ($urandom_range(0, 2))
                    0: op = 3'd0;
                    1: op = 3'd6;
                    default: op = 3'd7;
                endcase
            end else begin
                op = 3'(r % 5 + 1);
            end
            m = $urandom_range(0, 9);
            mode = (m < 5) ? 0 : (m < 7) ? 1 : (m < 8) ? 2 : 3;
            do_cmd(op, $urandom(), $urandom(), $urandom_range(0, 3), mode, $urandom(), 0);
        end

        do_cmd(3'd1, 32'h50, 32'h11112222, 0, 0, 32'd0, 1);
        do_cmd(3'd3, 32'h54, 32'h0, 1, 0, 32'h0, 2);
        do_cmd(3'd2, 32'h58, 32'h33334444, 0, 0, 32'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
